// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of a synchronized square wave, classifies it
// against the seven note windows and locks a note after CONFIRM matching periods.
module tone_decoder #(
  parameter int clkSpeed = 25,
  parameter int CONFIRM  = 3,
  parameter int TIMEOUT  = 227272
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wave,
  output logic [2:0] note,
  output logic       valid,
  output logic       change,
  output logic [7:0] led
);

  localparam int MW = $clog2(CONFIRM + 1);
  localparam logic [19:0]   TMAX = 20'(TIMEOUT);
  localparam logic [MW-1:0] CMAX = MW'(CONFIRM);

  typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

  function automatic int nominal(input int k);
    case (k)
      0:       nominal = clkSpeed * 1000000 / 220;
      1:       nominal = clkSpeed * 1000000 / 247;
      2:       nominal = clkSpeed * 1000000 / 261;
      3:       nominal = clkSpeed * 1000000 / 294;
      4:       nominal = clkSpeed * 1000000 / 330;
      5:       nominal = clkSpeed * 1000000 / 349;
      default: nominal = clkSpeed * 1000000 / 392;
    endcase
  endfunction

  state_t          state_reg, state_next;
  logic [2:0]      sync_reg;
  logic [19:0]     count_reg, count_next;
  logic [MW-1:0]   match_reg, match_next;
  logic [2:0]      cand_reg, cand_next;
  logic [2:0]      note_next;
  logic            valid_next, change_next;
  logic [7:0]      led_next;
  logic            rise;
  logic            at_timeout;
  logic [20:0]     period;
  logic [6:0]      hit;
  logic            classified;
  logic [2:0]      cls;

  assign rise       = sync_reg[1] & ~sync_reg[2];
  assign at_timeout = (count_reg == TMAX);
  assign period     = {1'b0, count_reg} + 21'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_win
      localparam int NOM = nominal(gi);
      localparam logic [20:0] LO = 21'(NOM - (NOM >> 5));
      localparam logic [20:0] HI = 21'(NOM + (NOM >> 5));
      assign hit[gi] = (period >= LO) && (period <= HI);
    end
  endgenerate

  // Adjacent windows can touch at some clock rates; the lower note index wins.
  always_comb begin
    classified = |hit;
    cls        = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (hit[i]) cls = 3'(i);
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = at_timeout ? count_reg : count_reg + 20'd1;
    match_next  = match_reg;
    cand_next   = cand_reg;
    note_next   = note;
    valid_next  = valid;
    change_next = 1'b0;

    if ((match_reg == CMAX) && (!valid || (cand_reg != note))) begin
      note_next   = cand_reg;
      valid_next  = 1'b1;
      change_next = 1'b1;
    end

    if (rise) begin
      count_next = '0;
      if (state_reg == IDLE) begin
        state_next = ARMED;
      end else begin
        state_next = TRACK;
        if (!classified) begin
          match_next = '0;
        end else if (cls == cand_reg) begin
          match_next = (match_reg == CMAX) ? match_reg : match_reg + MW'(1);
        end else begin
          cand_next  = cls;
          match_next = MW'(1);
        end
      end
    end else if (at_timeout && (state_reg != IDLE)) begin
      // Silence: drop the lock but keep the last note visible.
      state_next  = IDLE;
      match_next  = '0;
      cand_next   = '0;
      note_next   = note;
      valid_next  = 1'b0;
      change_next = valid;
    end

    led_next = valid_next ? {1'b1, 7'b1 << note_next} : 8'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sync_reg  <= '0;
      count_reg <= '0;
      match_reg <= '0;
      cand_reg  <= '0;
      note      <= '0;
      valid     <= 1'b0;
      change    <= 1'b0;
      led       <= '0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= {sync_reg[1:0], wave};
      count_reg <= count_next;
      match_reg <= match_next;
      cand_reg  <= cand_next;
      note      <= note_next;
      valid     <= valid_next;
      change    <= change_next;
      led       <= led_next;
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder at a 1 MHz clock so note periods stay a few
// thousand cycles; windows: A 4403..4687, B 3922..4174, E 2936..3124, G 2472..2630.
module tb_tone_decoder;

  localparam int TO = 4800;

  logic       clk = 1'b0;
  logic       reset;
  logic       wave;
  logic [2:0] note;
  logic       valid;
  logic       change;
  logic [7:0] led;

  int  checks = 0;
  int  fails  = 0;
  int  pulses = 0;
  time chg_time  = 0;
  time rise_time = 0;

  tone_decoder #(.clkSpeed(1), .CONFIRM(3), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .wave   (wave),
    .note   (note),
    .valid  (valid),
    .change (change),
    .led    (led)
  );

  always #5 clk = ~clk;

  // Every sampled cycle with change high is one pulse cycle.
  always @(negedge clk) begin
    if (change === 1'b1) begin
      pulses   <= pulses + 1;
      chg_time <= $time;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One full period: rising edge now, high for p/2 clocks, low for the rest.
  task automatic send_period(input int p);
    wave      = 1'b1;
    rise_time = $time;
    repeat (p / 2) @(negedge clk);
    wave = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wave  = 1'b0;
    #1;
    checks++; if (note !== 3'd0)   begin fails++; $display("FAIL reset_note: got %0d want 0", note); end
    checks++; if (valid !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (change !== 1'b0) begin fails++; $display("FAIL reset_change: got %b want 0", change); end
    checks++; if (led !== 8'h00)   begin fails++; $display("FAIL reset_led: got %b want 00000000", led); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("test_reset: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  task automatic test_lock_a;
    int c;
    c = pulses;
    send_period(4403);
    send_period(4687);
    send_period(4403);
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL lock_a_early_valid: got %b want 0", valid); end
    checks++; if (pulses !== c)   begin fails++; $display("FAIL lock_a_early_pulse: got %0d want %0d", pulses, c); end
    send_period(2551);
    checks++; if (note !== 3'd0)        begin fails++; $display("FAIL lock_a_note: got %0d want 0", note); end
    checks++; if (valid !== 1'b1)       begin fails++; $display("FAIL lock_a_valid: got %b want 1", valid); end
    checks++; if (led !== 8'b1000_0001) begin fails++; $display("FAIL lock_a_led: got %b want 10000001", led); end
    checks++; if (pulses !== c + 1)     begin fails++; $display("FAIL lock_a_pulses: got %0d want %0d", pulses, c + 1); end
    checks++; if (chg_time - rise_time !== 40) begin fails++; $display("FAIL lock_a_latency: got %0t want 40", chg_time - rise_time); end
    $display("test_lock_a: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  task automatic test_switch_g;
    int c;
    c = pulses;
    send_period(2551);
    send_period(2551);
    checks++; if (pulses !== c)  begin fails++; $display("FAIL switch_g_early_pulse: got %0d want %0d", pulses, c); end
    checks++; if (note !== 3'd0) begin fails++; $display("FAIL switch_g_early_note: got %0d want 0", note); end
    send_period(4687);
    checks++; if (note !== 3'd6)        begin fails++; $display("FAIL switch_g_note: got %0d want 6", note); end
    checks++; if (led !== 8'b1100_0000) begin fails++; $display("FAIL switch_g_led: got %b want 11000000", led); end
    checks++; if (pulses !== c + 1)     begin fails++; $display("FAIL switch_g_pulses: got %0d want %0d", pulses, c + 1); end
    checks++; if (chg_time - rise_time !== 40) begin fails++; $display("FAIL switch_g_latency: got %0t want 40", chg_time - rise_time); end
    $display("test_switch_g: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  // 4687,4687 arms A at count 2; 4402 must clear it and 4403 restart at 1.
  task automatic test_unclassified;
    int c;
    c = pulses;
    send_period(4687);
    send_period(4402);
    send_period(4403);
    checks++; if (pulses !== c)   begin fails++; $display("FAIL unclass_pulses: got %0d want %0d", pulses, c); end
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL unclass_valid: got %b want 1", valid); end
    checks++; if (note !== 3'd6)  begin fails++; $display("FAIL unclass_note: got %0d want 6", note); end
    $display("test_unclassified: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  task automatic test_alternating;
    int c;
    c = pulses;
    send_period(4048);
    send_period(4545);
    checks++; if (pulses !== c)         begin fails++; $display("FAIL alt_pulses: got %0d want %0d", pulses, c); end
    checks++; if (note !== 3'd6)        begin fails++; $display("FAIL alt_note: got %0d want 6", note); end
    checks++; if (led !== 8'b1100_0000) begin fails++; $display("FAIL alt_led: got %b want 11000000", led); end
    $display("test_alternating: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  task automatic test_reset_mid;
    int c;
    wave      = 1'b1;
    rise_time = $time;
    repeat (100) @(negedge clk);
    #2;
    reset = 1'b1;
    wave  = 1'b0;
    #1;
    checks++; if (note !== 3'd0)   begin fails++; $display("FAIL midrst_note: got %0d want 0", note); end
    checks++; if (valid !== 1'b0)  begin fails++; $display("FAIL midrst_valid: got %b want 0", valid); end
    checks++; if (change !== 1'b0) begin fails++; $display("FAIL midrst_change: got %b want 0", change); end
    checks++; if (led !== 8'h00)   begin fails++; $display("FAIL midrst_led: got %b want 00000000", led); end
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    c = pulses;
    send_period(2551);
    send_period(2551);
    send_period(2551);
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL relock_early_valid: got %b want 0", valid); end
    checks++; if (pulses !== c)   begin fails++; $display("FAIL relock_early_pulse: got %0d want %0d", pulses, c); end
    send_period(3030);
    checks++; if (valid !== 1'b1)   begin fails++; $display("FAIL relock_valid: got %b want 1", valid); end
    checks++; if (note !== 3'd6)    begin fails++; $display("FAIL relock_note: got %0d want 6", note); end
    checks++; if (pulses !== c + 1) begin fails++; $display("FAIL relock_pulses: got %0d want %0d", pulses, c + 1); end
    $display("test_reset_mid: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  task automatic test_timeout_e;
    int  c;
    time t_last;
    c = pulses;
    send_period(3030);
    send_period(3030);
    send_period(3030);
    t_last = rise_time;
    checks++; if (note !== 3'd4)        begin fails++; $display("FAIL lock_e_note: got %0d want 4", note); end
    checks++; if (valid !== 1'b1)       begin fails++; $display("FAIL lock_e_valid: got %b want 1", valid); end
    checks++; if (led !== 8'b1001_0000) begin fails++; $display("FAIL lock_e_led: got %b want 10010000", led); end
    checks++; if (pulses !== c + 1)     begin fails++; $display("FAIL lock_e_pulses: got %0d want %0d", pulses, c + 1); end
    repeat (TO - 3030 + 20) @(negedge clk);
    checks++; if (valid !== 1'b0)   begin fails++; $display("FAIL timeout_valid: got %b want 0", valid); end
    checks++; if (led !== 8'h00)    begin fails++; $display("FAIL timeout_led: got %b want 00000000", led); end
    checks++; if (note !== 3'd4)    begin fails++; $display("FAIL timeout_note: got %0d want 4", note); end
    checks++; if (pulses !== c + 2) begin fails++; $display("FAIL timeout_pulses: got %0d want %0d", pulses, c + 2); end
    checks++; if (chg_time - t_last !== 10 * (TO + 4)) begin fails++; $display("FAIL timeout_time: got %0t want %0d", chg_time - t_last, 10 * (TO + 4)); end
    $display("test_timeout_e: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  task automatic test_no_window;
    int c;
    c = pulses;
    repeat (5) send_period(2700);
    wave = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL nowin_valid: got %b want 0", valid); end
    checks++; if (led !== 8'h00)  begin fails++; $display("FAIL nowin_led: got %b want 00000000", led); end
    checks++; if (pulses !== c)   begin fails++; $display("FAIL nowin_pulses: got %0d want %0d", pulses, c); end
    $display("test_no_window: note=%0d valid=%b led=%b", note, valid, led);
  endtask

  initial begin
    test_reset();
    test_lock_a();
    test_switch_g();
    test_unclassified();
    test_alternating();
    test_reset_mid();
    test_timeout_e();
    test_no_window();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter clkSpeed, default 25, system clock frequency in MHz.
REQ-002 Parameter CONFIRM, default 3, consecutive matching periods required to lock a note.
REQ-003 Parameter TIMEOUT, default 227272, clocks without a rising edge before silence is declared.
REQ-004 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port wave  input  1  asynchronous square-wave tone input, in the same format the frequency generator drives.
REQ-007 Port note  output  3  decoded note code: A=0, B=1, C=2, D=3, E=4, F=5, G=6.
REQ-008 Port valid  output  1  high while a note is locked.
REQ-009 Port change  output  1  one-cycle pulse when note or valid changes due to lock.
REQ-010 Port led  output  8  led[7]=valid; led[6:0]=one-hot of note when valid, else 0.

Function
REQ-011 wave SHALL pass through a two-flop synchronizer; a rising edge SHALL be detected when the second stage is 1 and a third, delayed copy is 0.
REQ-012 A 20-bit period counter SHALL increment every clock and saturate at TIMEOUT; on each detected edge, measured period P SHALL equal the counter value plus 1, and the counter SHALL restart at 0.
REQ-013 Nominal periods SHALL be N = clkSpeed*1000000/freq (integer division), with freq = 220, 247, 261, 294, 330, 349, 392 Hz; at defaults, N = 113636, 101214, 95785, 85034, 75757, 71633, 63775.
REQ-014 P SHALL classify as note k iff N_k - (N_k>>5) <= P <= N_k + (N_k>>5), inclusive; windows SHALL NOT overlap; otherwise P is unclassified.
REQ-015 FSM states: IDLE (no edge since reset or silence), ARMED (one edge seen, no period yet), TRACK (measuring periods).
REQ-016 IDLE -> ARMED on first detected edge; ARMED -> TRACK on next edge (first P evaluated); ARMED or TRACK -> IDLE when counter reaches TIMEOUT.
REQ-017 In TRACK, a classified P equal to the current candidate SHALL increment the match count (saturating at CONFIRM); a classified P differing from the candidate SHALL load the new candidate with match count 1; an unclassified P SHALL clear the match count.
REQ-018 When the match count reaches CONFIRM and (valid=0 or candidate != note), on the following clock note SHALL take the candidate, valid SHALL go to 1, and change SHALL pulse for exactly one cycle.
REQ-019 Further matching periods for an already-locked note SHALL NOT pulse change.
REQ-020 Unclassified periods SHALL NOT drop valid; the locked note SHALL be held until a different note is confirmed or timeout occurs.
REQ-021 On timeout, valid SHALL fall to 0 on the following clock, change SHALL pulse once, note SHALL hold its last value, and the match count and candidate SHALL clear.
REQ-022 An edge and timeout in the same cycle: the edge SHALL take priority, and no timeout is taken.
REQ-023 Latency from the confirming wave rising edge to output update SHALL be at most 4 clocks (3 sync/detect plus 1 register).
REQ-024 All outputs SHALL be registered; led SHALL update in the same cycle as note and valid.

Reset
REQ-025 While reset is high, outputs SHALL be immediately forced to note=0, valid=0, change=0, led=0.
REQ-026 While reset is high, the FSM SHALL be in IDLE, and the counter, match count, candidate and synchronizer flops SHALL be 0.
REQ-027 Reset asserted mid-measurement SHALL discard the partial period; after release, the first edge SHALL only arm the FSM.

Verification
REQ-028 220 Hz input (56818 clocks high, 56818 low) -> after the 3rd measured period: note=0, valid=1, one change pulse, led=8'b10000001.
REQ-029 After lock on A, switch to 392 Hz (31887/31888 half-periods) -> after 3 periods: note=6, one change pulse, led=8'b11000000; no pulse in between.
REQ-030 280 Hz input (period 89285, out of every window) for 10 periods -> valid stays 0, change never pulses, led=0.
REQ-031 Lock on E, then hold wave low -> valid=0, led=0 and one change pulse exactly TIMEOUT+1 clocks after the last edge detect; note stays 4.
REQ-032 Alternating A/B periods -> valid never asserts; boundary periods 110085 and 117187 -> classified as A; 110084 -> unclassified.
REQ-033 Assert reset asynchronously mid-period after lock -> outputs are 0 before the next clk edge; after release, lock requires CONFIRM+1 edges.
